// File: rtl/pong_state_packetizer_if.sv
// Byte-level TX interface between the pong state packetizer and the 8-bit UART.
//   tx_en    : UART enable, high while a packet is being sent
//   tx_start : start request, held as a level until the UART reports busy
//   tx_data  : byte presented to the UART, stable for the whole byte handshake
//   tx_busy  : UART frame in progress (baud-clock domain, synchronised by the master)
interface pong_state_packetizer_if;
   logic       tx_en;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;

   modport master (output tx_en, output tx_start, output tx_data, input tx_busy);
   modport slave  (input tx_en, input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/pong_state_packetizer.sv
// Snapshots the pong game state on i_snap and serialises it as an 11-byte packet:
//   HEADER, ball_x(hi,lo), ball_y(hi,lo), paddle_l(hi,lo), paddle_r(hi,lo),
//   {score_l,score_r}, XOR checksum of bytes 1..9.
// Ports:
//   i_clk, i_rst          board clock, asynchronous active-high reset
//   i_snap                one-cycle capture/send strobe
//   i_ball_x .. i_score_r game state, registered on the snap cycle
//   tx                    UART TX interface (master side)
//   o_pkt_busy            packet in flight
//   o_pkt_done            one-cycle pulse after the last byte's frame completes
//   o_snap_dropped        one-cycle pulse for a snap that arrived while busy
module pong_state_packetizer #(
   parameter logic [7:0] HEADER      = 8'hA5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_snap,
   input  logic [9:0]                      i_ball_x,
   input  logic [9:0]                      i_ball_y,
   input  logic [9:0]                      i_paddle_l,
   input  logic [9:0]                      i_paddle_r,
   input  logic [3:0]                      i_score_l,
   input  logic [3:0]                      i_score_r,
   pong_state_packetizer_if.master         tx,
   output logic                            o_pkt_busy,
   output logic                            o_pkt_done,
   output logic                            o_snap_dropped
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD      = 3'd1;
   localparam logic [2:0] S_START     = 3'd2;
   localparam logic [2:0] S_WAIT_BUSY = 3'd3;
   localparam logic [2:0] S_WAIT_DONE = 3'd4;
   localparam logic [3:0] LAST_IDX    = 4'd10;

   logic [2:0]             r_state;
   logic [3:0]             r_idx;
   logic [9:0]             r_bx, r_by, r_pl, r_pr;
   logic [7:0]             r_score;
   logic [7:0]             r_csum;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_tx_en, r_tx_start;
   logic [7:0]             r_tx_data;
   logic                   r_pkt_busy, r_pkt_done, r_snap_dropped;
   logic                   w_busy_s;
   logic [7:0]             w_byte;

   assign w_busy_s = r_sync[SYNC_STAGES-1];

   // Byte mux over the snapshot; index 10 picks up the checksum accumulated
   // while bytes 1..9 were loaded.
   always_comb begin
      w_byte = 8'h00;
      case (r_idx)
         4'd0:    w_byte = HEADER;
         4'd1:    w_byte = {6'b0, r_bx[9:8]};
         4'd2:    w_byte = r_bx[7:0];
         4'd3:    w_byte = {6'b0, r_by[9:8]};
         4'd4:    w_byte = r_by[7:0];
         4'd5:    w_byte = {6'b0, r_pl[9:8]};
         4'd6:    w_byte = r_pl[7:0];
         4'd7:    w_byte = {6'b0, r_pr[9:8]};
         4'd8:    w_byte = r_pr[7:0];
         4'd9:    w_byte = r_score;
         4'd10:   w_byte = r_csum;
         default: w_byte = 8'h00;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_idx          <= 4'd0;
         r_bx           <= '0;
         r_by           <= '0;
         r_pl           <= '0;
         r_pr           <= '0;
         r_score        <= '0;
         r_csum         <= '0;
         r_sync         <= '0;
         r_tx_en        <= 1'b0;
         r_tx_start     <= 1'b0;
         r_tx_data      <= 8'h00;
         r_pkt_busy     <= 1'b0;
         r_pkt_done     <= 1'b0;
         r_snap_dropped <= 1'b0;
      end else begin
         r_sync         <= {r_sync[SYNC_STAGES-2:0], tx.tx_busy};
         r_pkt_done     <= 1'b0;
         // The pkt_done cycle still counts as busy for incoming snaps.
         r_snap_dropped <= i_snap & (r_pkt_busy | r_pkt_done);
         case (r_state)
            S_IDLE: begin
               if (i_snap && !r_pkt_done) begin
                  r_bx       <= i_ball_x;
                  r_by       <= i_ball_y;
                  r_pl       <= i_paddle_l;
                  r_pr       <= i_paddle_r;
                  r_score    <= {i_score_l, i_score_r};
                  r_csum     <= 8'h00;
                  r_idx      <= 4'd0;
                  r_pkt_busy <= 1'b1;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_tx_data <= w_byte;
               r_tx_en   <= 1'b1;
               if (r_idx != 4'd0 && r_idx != LAST_IDX)
                  r_csum <= r_csum ^ w_byte;
               r_state   <= S_START;
            end
            S_START: begin
               // Never request a frame while the previous one is still running.
               if (!w_busy_s) begin
                  r_tx_start <= 1'b1;
                  r_state    <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               if (w_busy_s) begin
                  r_tx_start <= 1'b0;
                  r_state    <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (!w_busy_s) begin
                  if (r_idx == LAST_IDX) begin
                     r_pkt_done <= 1'b1;
                     r_pkt_busy <= 1'b0;
                     r_tx_en    <= 1'b0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_idx   <= r_idx + 4'd1;
                     r_state <= S_LOAD;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tx.tx_en       = r_tx_en;
   assign tx.tx_start    = r_tx_start;
   assign tx.tx_data     = r_tx_data;
   assign o_pkt_busy     = r_pkt_busy;
   assign o_pkt_done     = r_pkt_done;
   assign o_snap_dropped = r_snap_dropped;

endmodule

// File: tb/tb_pong_state_packetizer.sv
module tb_pong_state_packetizer;

   logic       clk = 1'b0;
   logic       rst;
   logic       snap;
   logic [9:0] ball_x, ball_y, paddle_l, paddle_r;
   logic [3:0] score_l, score_r;
   logic       pkt_busy, pkt_done, snap_dropped;

   pong_state_packetizer_if u_if ();

   pong_state_packetizer #(.HEADER(8'hA5), .SYNC_STAGES(2)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_snap         (snap),
      .i_ball_x       (ball_x),
      .i_ball_y       (ball_y),
      .i_paddle_l     (paddle_l),
      .i_paddle_r     (paddle_r),
      .i_score_l      (score_l),
      .i_score_r      (score_r),
      .tx             (u_if.master),
      .o_pkt_busy     (pkt_busy),
      .o_pkt_done     (pkt_done),
      .o_snap_dropped (snap_dropped)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Hand-computed packets.
   // P1: bx=155 by=0F0 pl=3FF pr=000 scores 3/7
   // P2: bx=2AB by=001 pl=100 pr=3C3 scores F/0
   logic [7:0] EXP1 [11] = '{8'hA5, 8'h01, 8'h55, 8'h00, 8'hF0, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h37, 8'h6F};
   logic [7:0] EXP2 [11] = '{8'hA5, 8'h02, 8'hAB, 8'h00, 8'h01, 8'h01, 8'h00, 8'h03, 8'hC3, 8'hF0, 8'h99};

   // ---------------- UART model (changes tx_busy on negedges) ----------------
   logic [7:0] rx_q [$];
   int m_delay = 0;
   int m_frame = 6;
   int m_phase = 0;
   int m_cnt   = 0;

   always begin
      @(negedge clk);
      case (m_phase)
         0: if (u_if.tx_start && !u_if.tx_busy) begin
               if (m_delay == 0) begin
                  u_if.tx_busy = 1'b1;
                  rx_q.push_back(u_if.tx_data);
                  m_phase = 2;
                  m_cnt   = m_frame;
               end else begin
                  m_phase = 1;
                  m_cnt   = m_delay;
               end
            end
         1: begin
               m_cnt = m_cnt - 1;
               if (m_cnt == 0) begin
                  u_if.tx_busy = 1'b1;
                  rx_q.push_back(u_if.tx_data);
                  m_phase = 2;
                  m_cnt   = m_frame;
               end
            end
         default: begin
               m_cnt = m_cnt - 1;
               if (m_cnt == 0) begin
                  u_if.tx_busy = 1'b0;
                  m_phase = 0;
               end
            end
      endcase
   end

   // ---------------- monitor: pulse counters and start-vs-busy rule ----------------
   int   done_cnt  = 0;
   int   drop_cnt  = 0;
   int   start_cnt = 0;
   int   viol_cnt  = 0;
   logic [2:0] bh  = 3'b000;
   logic ps        = 1'b0;

   always @(posedge clk) begin
      // A rise of tx_start at the previous edge may only follow a tx_busy
      // that was low two edges before that one (two-flop synchroniser).
      if (u_if.tx_start && !ps && bh[2]) viol_cnt <= viol_cnt + 1;
      if (u_if.tx_start && !ps)          start_cnt <= start_cnt + 1;
      if (pkt_done)                      done_cnt <= done_cnt + 1;
      if (snap_dropped)                  drop_cnt <= drop_cnt + 1;
      bh <= {bh[1:0], u_if.tx_busy};
      ps <= u_if.tx_start;
   end

   // ---------------- stimulus helpers (timeline: #1 after posedge) ----------------
   task automatic set_state(input logic [9:0] bx, by, pl, pr, input logic [3:0] sl, sr);
      ball_x = bx; ball_y = by; paddle_l = pl; paddle_r = pr; score_l = sl; score_r = sr;
   endtask

   task automatic pulse_snap();
      snap = 1'b1;
      @(posedge clk); #1;
      snap = 1'b0;
   endtask

   task automatic wait_done(input int base, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk); #1;
         if (done_cnt > base) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_bytes(input int n, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk); #1;
         if (rx_q.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; snap = 1'b0;
      set_state(10'h0, 10'h0, 10'h0, 10'h0, 4'h0, 4'h0);
      u_if.tx_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({u_if.tx_en, u_if.tx_start} !== 2'b00) begin
         errors++; $display("FAIL reset_en_start: got %b want 00", {u_if.tx_en, u_if.tx_start});
      end
      checks++;
      if (u_if.tx_data !== 8'h00) begin
         errors++; $display("FAIL reset_tx_data: got %h want 00", u_if.tx_data);
      end
      checks++;
      if ({pkt_busy, pkt_done, snap_dropped} !== 3'b000) begin
         errors++; $display("FAIL reset_status: got %b want 000", {pkt_busy, pkt_done, snap_dropped});
      end
      @(negedge clk); rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({pkt_busy, u_if.tx_en} !== 2'b00) begin
         errors++; $display("FAIL idle_after_reset: got %b want 00", {pkt_busy, u_if.tx_en});
      end
   endtask

   task automatic test_basic_packet();
      int base;
      bit ok;
      rx_q.delete();
      base = done_cnt;
      set_state(10'h155, 10'h0F0, 10'h3FF, 10'h000, 4'h3, 4'h7);
      pulse_snap();                          // now #1 after snap edge N
      checks++;
      if (pkt_busy !== 1'b1) begin
         errors++; $display("FAIL t1_busy_after_snap: got %b want 1", pkt_busy);
      end
      @(posedge clk); #1;                    // N+1: LOAD done
      checks++;
      if ({u_if.tx_en, u_if.tx_start, u_if.tx_data} !== {1'b1, 1'b0, 8'hA5}) begin
         errors++; $display("FAIL t1_load: got en=%b st=%b d=%h want en=1 st=0 d=a5",
                            u_if.tx_en, u_if.tx_start, u_if.tx_data);
      end
      @(posedge clk); #1;                    // N+2: tx_start rises
      checks++;
      if (u_if.tx_start !== 1'b1) begin
         errors++; $display("FAIL t1_start_latency: got %b want 1 at N+2", u_if.tx_start);
      end
      wait_done(base, 2000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL t1_done_timeout: got no pkt_done want pulse"); end
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (rx_q.size() !== 11) begin
         errors++; $display("FAIL t1_byte_count: got %0d want 11", rx_q.size());
      end
      for (int i = 0; i < 11 && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== EXP1[i]) begin
            errors++; $display("FAIL t1_byte%0d: got %h want %h", i, rx_q[i], EXP1[i]);
         end
      end
      checks++;
      if (done_cnt - base !== 1) begin
         errors++; $display("FAIL t1_done_pulses: got %0d want 1", done_cnt - base);
      end
      checks++;
      if ({pkt_busy, u_if.tx_en} !== 2'b00) begin
         errors++; $display("FAIL t1_idle_after: got %b want 00", {pkt_busy, u_if.tx_en});
      end
   endtask

   task automatic test_snap_dropped();
      int base, dbase;
      bit ok;
      rx_q.delete();
      base = done_cnt; dbase = drop_cnt;
      set_state(10'h155, 10'h0F0, 10'h3FF, 10'h000, 4'h3, 4'h7);
      pulse_snap();
      repeat (4) @(posedge clk);
      #1;
      set_state(10'h2AB, 10'h001, 10'h100, 10'h3C3, 4'hF, 4'h0);
      pulse_snap();                          // 5 cycles after the first
      wait_done(base, 2000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL t2_done_timeout: got no pkt_done want pulse"); end
      repeat (60) @(posedge clk);
      #1;
      checks++;
      if (drop_cnt - dbase !== 1) begin
         errors++; $display("FAIL t2_dropped_pulses: got %0d want 1", drop_cnt - dbase);
      end
      checks++;
      if (rx_q.size() !== 11) begin
         errors++; $display("FAIL t2_byte_count: got %0d want 11", rx_q.size());
      end
      for (int i = 0; i < 11 && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== EXP1[i]) begin
            errors++; $display("FAIL t2_byte%0d: got %h want %h", i, rx_q[i], EXP1[i]);
         end
      end
   endtask

   task automatic test_midpacket_change();
      int base;
      bit ok;
      rx_q.delete();
      base = done_cnt;
      set_state(10'h2AB, 10'h001, 10'h100, 10'h3C3, 4'hF, 4'h0);
      pulse_snap();
      wait_bytes(3, 500, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL t3_bytes_timeout: got %0d bytes want 3", rx_q.size()); end
      set_state(10'h044, 10'h3EE, 10'h011, 10'h222, 4'h1, 4'h2);
      wait_done(base, 2000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL t3_done_timeout: got no pkt_done want pulse"); end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (rx_q.size() !== 11) begin
         errors++; $display("FAIL t3_byte_count: got %0d want 11", rx_q.size());
      end
      for (int i = 0; i < 11 && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== EXP2[i]) begin
            errors++; $display("FAIL t3_byte%0d: got %h want %h", i, rx_q[i], EXP2[i]);
         end
      end
   endtask

   task automatic test_slow_busy();
      int base, sbase, hold;
      bit ok;
      rx_q.delete();
      base = done_cnt; sbase = start_cnt;
      m_delay = 40;
      set_state(10'h2AB, 10'h001, 10'h100, 10'h3C3, 4'hF, 4'h0);
      pulse_snap();
      hold = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (u_if.tx_start) hold++;
         else if (hold > 0) break;
      end
      checks++;
      if (hold < 40 || hold > 46) begin
         errors++; $display("FAIL t4_start_hold: got %0d cycles want 40..46", hold);
      end
      wait_done(base, 3000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL t4_done_timeout: got no pkt_done want pulse"); end
      m_delay = 0;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (start_cnt - sbase !== 11) begin
         errors++; $display("FAIL t4_start_pulses: got %0d want 11", start_cnt - sbase);
      end
      checks++;
      if (rx_q.size() !== 11) begin
         errors++; $display("FAIL t4_byte_count: got %0d want 11", rx_q.size());
      end
      for (int i = 0; i < 11 && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== EXP2[i]) begin
            errors++; $display("FAIL t4_byte%0d: got %h want %h", i, rx_q[i], EXP2[i]);
         end
      end
   endtask

   task automatic test_reset_midpacket();
      int base, waited;
      bit ok;
      rx_q.delete();
      m_frame = 40;
      set_state(10'h155, 10'h0F0, 10'h3FF, 10'h000, 4'h3, 4'h7);
      pulse_snap();
      wait_bytes(5, 1000, ok);              // byte 4 frame now in progress
      checks++;
      if (!ok) begin errors++; $display("FAIL t5_bytes_timeout: got %0d bytes want 5", rx_q.size()); end
      #2 rst = 1'b1;
      #1;                                    // no clock edge since reset rose
      checks++;
      if ({u_if.tx_en, u_if.tx_start, u_if.tx_data, pkt_busy, pkt_done, snap_dropped} !== 13'h0) begin
         errors++; $display("FAIL t5_async_reset: got en=%b st=%b d=%h busy=%b want all 0",
                            u_if.tx_en, u_if.tx_start, u_if.tx_data, pkt_busy);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      rx_q.delete();
      m_frame = 6;
      base = done_cnt;
      snap = 1'b1;
      @(posedge clk); #1;
      snap = 1'b0;
      waited = 0;
      for (int i = 0; i < 200; i++) begin
         if (u_if.tx_start) break;
         @(posedge clk); #1;
         waited++;
      end
      checks++;
      if (u_if.tx_start !== 1'b1 || u_if.tx_busy !== 1'b0) begin
         errors++; $display("FAIL t5_first_start: got start=%b busy=%b want start=1 busy=0",
                            u_if.tx_start, u_if.tx_busy);
      end
      checks++;
      if (waited < 5) begin
         errors++; $display("FAIL t5_start_waited: got %0d cycles want >=5", waited);
      end
      wait_done(base, 2000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL t5_done_timeout: got no pkt_done want pulse"); end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (rx_q.size() !== 11) begin
         errors++; $display("FAIL t5_byte_count: got %0d want 11", rx_q.size());
      end
      for (int i = 0; i < 11 && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== EXP1[i]) begin
            errors++; $display("FAIL t5_byte%0d: got %h want %h", i, rx_q[i], EXP1[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int base, dbase;
      bit ok;
      rx_q.delete();
      base = done_cnt; dbase = drop_cnt;
      set_state(10'h155, 10'h0F0, 10'h3FF, 10'h000, 4'h3, 4'h7);
      pulse_snap();
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (pkt_done) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL t6_first_done_timeout: got no pkt_done want pulse"); end
      // Held across the pkt_done edge (dropped) and the following edge (accepted).
      set_state(10'h2AB, 10'h001, 10'h100, 10'h3C3, 4'hF, 4'h0);
      snap = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      snap = 1'b0;
      checks++;
      if (pkt_busy !== 1'b1) begin
         errors++; $display("FAIL t6_second_accepted: got pkt_busy=%b want 1", pkt_busy);
      end
      wait_done(base + 1, 2000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL t6_second_done_timeout: got no pkt_done want pulse"); end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (drop_cnt - dbase !== 1) begin
         errors++; $display("FAIL t6_dropped_pulses: got %0d want 1", drop_cnt - dbase);
      end
      checks++;
      if (rx_q.size() !== 22) begin
         errors++; $display("FAIL t6_byte_count: got %0d want 22", rx_q.size());
      end
      for (int i = 0; i < 22 && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== ((i < 11) ? EXP1[i] : EXP2[i-11])) begin
            errors++; $display("FAIL t6_byte%0d: got %h want %h", i, rx_q[i],
                               (i < 11) ? EXP1[i] : EXP2[i-11]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_packet();
      test_snap_dropped();
      test_midpacket_change();
      test_slow_busy();
      test_reset_midpacket();
      test_back_to_back();
      checks++;
      if (viol_cnt !== 0) begin
         errors++; $display("FAIL start_while_busy: got %0d violations want 0", viol_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
